cordic_arbiter: RTL

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_arbiter_if.sv | 56 +++++
 rtl/cordic_rr_arbiter.sv | 24 ++
 rtl/cordic_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and FSM encoding for the CORDIC request arbiter.
package cordic_pkg;

  localparam int unsigned N_FRAC_DEF = 7;
  localparam int unsigned ID_W       = 1;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester, core and result signals of the CORDIC arbiter.
// slave = arbiter side, master = surrounding requesters/core/consumer.
interface cordic_arbiter_if #(
  parameter int unsigned W = 8
) ();

  logic         req0_valid_i;
  logic         req0_ready_o;
  logic [W-1:0] req0_x_i;
  logic [W-1:0] req0_y_i;
  logic [W-1:0] req0_z_i;

  logic         req1_valid_i;
  logic         req1_ready_o;
  logic [W-1:0] req1_x_i;
  logic [W-1:0] req1_y_i;
  logic [W-1:0] req1_z_i;

  logic [W-1:0] core_x_o;
  logic [W-1:0] core_y_o;
  logic [W-1:0] core_z_o;
  logic         core_start_o;
  logic [W-1:0] core_x_i;
  logic [W-1:0] core_y_i;
  logic [W-1:0] core_z_i;
  logic         core_done_i;

  logic         res_valid_o;
  logic         res_ready_i;
  logic [W-1:0] res_x_o;
  logic [W-1:0] res_y_o;
  logic [W-1:0] res_z_o;
  logic         res_id_o;
  logic         res_err_o;

  modport slave (
    input  req0_valid_i, req0_x_i, req0_y_i, req0_z_i,
    input  req1_valid_i, req1_x_i, req1_y_i, req1_z_i,
    input  core_x_i, core_y_i, core_z_i, core_done_i,
    input  res_ready_i,
    output req0_ready_o, req1_ready_o,
    output core_x_o, core_y_o, core_z_o, core_start_o,
    output res_valid_o, res_x_o, res_y_o, res_z_o, res_id_o, res_err_o
  );

  modport master (
    output req0_valid_i, req0_x_i, req0_y_i, req0_z_i,
    output req1_valid_i, req1_x_i, req1_y_i, req1_z_i,
    output core_x_i, core_y_i, core_z_i, core_done_i,
    output res_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  core_x_o, core_y_o, core_z_o, core_start_o,
    input  res_valid_o, res_x_o, res_y_o, res_z_o, res_id_o, res_err_o
  );

endinterface

// File: rtl/cordic_rr_arbiter.sv
// cordic_rr_arbiter: one-hot grant between two requesters.
// Optional: CORDIC_ARB_ROUND_ROBIN_EN breaks ties toward the channel not served last;
// otherwise channel 0 always wins a tie.
module cordic_rr_arbiter (
  input  logic [1:0] i_valid,
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
  input  logic       i_last,
`endif
  output logic [1:0] o_grant_c
);

  // A lone valid channel is always granted; only ties need a policy.
  always_comb begin
    o_grant_c = i_valid;
    if (i_valid == 2'b11) begin
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
      o_grant_c = i_last ? 2'b01 : 2'b10;
`else
      o_grant_c = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: sequences two requesters onto one shared CORDIC core with a
// completion timeout. Pure sequencer, no arithmetic.
// Optional: CORDIC_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned N_FRAC         = N_FRAC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  cordic_arbiter_if.slave bus
);

  localparam int unsigned W = N_FRAC + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      w_valid;
  logic [1:0]      w_grant;
  logic            w_hs;
  logic            w_done;
  logic            w_tmo;

  logic [W-1:0]    r_op_x;
  logic [W-1:0]    r_op_y;
  logic [W-1:0]    r_op_z;
  logic [ID_W-1:0] r_id;
  logic            r_start;
  logic [CNT_W-1:0] r_cnt;

  logic            r_res_valid;
  logic [W-1:0]    r_res_x;
  logic [W-1:0]    r_res_y;
  logic [W-1:0]    r_res_z;
  logic [ID_W-1:0] r_res_id;
  logic            r_res_err;

`ifdef CORDIC_ARB_ROUND_ROBIN_EN
  logic            r_last;
`endif

  assign w_valid = {bus.req1_valid_i, bus.req0_valid_i};

  cordic_rr_arbiter u_rr (
    .i_valid   (w_valid),
`ifdef CORDIC_ARB_ROUND_ROBIN_EN
    .i_last    (r_last),
`endif
    .o_grant_c (w_grant)
  );

  // Ready is combinational so the requester sees acceptance in the same cycle.
  assign bus.req0_ready_o = (r_state == IDLE) && w_grant[0];
  assign bus.req1_ready_o = (r_state == IDLE) && w_grant[1];

  assign bus.core_x_o     = r_op_x;
  assign bus.core_y_o     = r_op_y;
  assign bus.core_z_o     = r_op_z;
  assign bus.core_start_o = r_start;
  assign bus.res_valid_o  = r_res_valid;
  assign bus.res_x_o      = r_res_x;
  assign bus.res_y_o      = r_res_y;
  assign bus.res_z_o      = r_res_z;
  assign bus.res_id_o     = r_res_id;
  assign bus.res_err_o    = r_res_err;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; done is checked before the timeout so it wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_hs        = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.core_done_i) begin
          w_done      = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on handshake, start strobe for the single LAUNCH cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op_x  <= '0;
      r_op_y  <= '0;
      r_op_z  <= '0;
      r_id    <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= (w_state_nxt == LAUNCH);
      if (w_hs) begin
        r_id <= ID_W'(w_grant[1]);
        if (w_grant[1]) begin
          r_op_x <= bus.req1_x_i;
          r_op_y <= bus.req1_y_i;
          r_op_z <= bus.req1_z_i;
        end else begin
          r_op_x <= bus.req0_x_i;
          r_op_y <= bus.req0_y_i;
          r_op_z <= bus.req0_z_i;
        end
      end
    end
  end

`ifdef CORDIC_ARB_ROUND_ROBIN_EN
  // Remember which channel was served last for tie breaking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_last <= 1'b1;
    else if (w_hs) r_last <= w_grant[1];
  end
`endif

  // Wait counter: 0 in the first WAIT cycle, cleared everywhere else.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 r_cnt <= '0;
    else if (r_state == WAIT)  r_cnt <= r_cnt + CNT_W'(1);
    else                       r_cnt <= '0;
  end

  // Result register: loaded on done or timeout, held through HOLD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_z     <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_res_valid <= (w_state_nxt == HOLD);
      if (w_done) begin
        r_res_x   <= bus.core_x_i;
        r_res_y   <= bus.core_y_i;
        r_res_z   <= bus.core_z_i;
        r_res_id  <= r_id;
        r_res_err <= 1'b0;
      end else if (w_tmo) begin
        r_res_x   <= '0;
        r_res_y   <= '0;
        r_res_z   <= '0;
        r_res_id  <= r_id;
        r_res_err <= 1'b1;
      end
    end
  end

endmodule
